// File: rtl/m31_inverter.sv
// Multiplicative inverter over GF(2^31-1): a^EXPONENT via left-to-right square-and-multiply.
// Optional feature: define M31_INV_ZERO_BYPASS_EN to finish zero inputs immediately.
module m31_inverter #(
  parameter logic [30:0] EXPONENT   = 31'h7FFFFFFD,
  parameter int          DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  localparam logic [30:0] P = 31'h7FFFFFFF;

  function automatic int msb_pos(input logic [30:0] e);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if (e[b]) r = b;
    end
    return r;
  endfunction

  localparam int         T       = msb_pos(EXPONENT);
  localparam logic [4:0] I_START = (T == 0) ? 5'd0 : 5'(T - 1);

`ifdef M31_INV_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  if (DATA_WIDTH != 31) begin : g_width_check
    $error("m31_inverter: DATA_WIDTH must be 31");
  end
  if (EXPONENT == 31'd0) begin : g_exp_check
    $error("m31_inverter: EXPONENT must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, SQUARE, MULT, DONE} state_t;

  state_t      state;
  logic [30:0] acc;
  logic [30:0] base;
  logic [4:0]  idx;
  logic        zero_flag;

  // Non-canonical zero (all ones) is folded to 0 on capture.
  logic [30:0] in_base;
  logic        in_zero;
  assign in_base = (in_data == P) ? 31'd0 : in_data;
  assign in_zero = (in_base == 31'd0);

  // One shared multiplier: squares in SQUARE, multiplies by the base in MULT.
  logic [30:0] op_b;
  logic [61:0] prod;
  logic [31:0] fold;
  logic [31:0] fold_sub;
  logic [30:0] prod_mod;

  assign op_b     = (state == MULT) ? base : acc;
  assign prod     = {31'd0, acc} * {31'd0, op_b};
  assign fold     = {1'b0, prod[30:0]} + {1'b0, prod[61:31]};
  assign fold_sub = fold - {1'b0, P};
  assign prod_mod = (fold >= {1'b0, P}) ? fold_sub[30:0] : fold[30:0];

  // NOTE: every register here uses <= so all updates see pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      acc       <= '0;
      base      <= '0;
      idx       <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            base      <= in_base;
            acc       <= in_base;
            idx       <= I_START;
            zero_flag <= in_zero;
            in_ready  <= 1'b0;
            if (T == 0 || (ZERO_BYPASS && in_zero)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= in_base;
              out_err   <= in_zero;
            end else begin
              state <= SQUARE;
            end
          end
        end
        SQUARE: begin
          acc <= prod_mod;
          if (EXPONENT[idx]) begin
            state <= MULT;
          end else if (idx == 5'd0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= prod_mod;
            out_err   <= zero_flag;
          end else begin
            idx <= idx - 5'd1;
          end
        end
        MULT: begin
          acc <= prod_mod;
          if (idx == 5'd0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= prod_mod;
            out_err   <= zero_flag;
          end else begin
            idx   <= idx - 5'd1;
            state <= SQUARE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m31_inverter.sv
// Self-checking bench for m31_inverter: directed vectors, random inverses, backpressure, reset abort, streaming.
module tb_m31_inverter;

  localparam logic [30:0]     EXP = 31'h7FFFFFFD;
  localparam longint unsigned PM  = 64'h7FFFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [30:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [30:0] out_data;
  logic        out_err;

  int vectors = 0;
  int miscompares = 0;

  m31_inverter dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

`ifdef M31_INV_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain right-to-left modular exponentiation.
  function automatic longint unsigned mpow(input longint unsigned a, input longint unsigned e);
    longint unsigned r, b, k;
    r = 1; b = a % PM; k = e;
    while (k != 0) begin
      if (k[0]) r = (r * b) % PM;
      b = (b * b) % PM;
      k = k >> 1;
    end
    return r;
  endfunction

  function automatic int steps_n();
    int t;
    t = 0;
    for (int b = 0; b < 31; b++) if (EXP[b]) t = b;
    return t + $countones(EXP) - 1;
  endfunction

  function automatic int exp_latency(input logic [30:0] d);
    if (BYPASS && (d == 31'd0 || d == 31'h7FFFFFFF)) return 1;
    return steps_n() + 1;
  endfunction

  // Offer d, wait for the result; lat counts cycles from acceptance edge to first out_valid.
  task automatic run_op(input logic [30:0] d, output logic [30:0] res, output logic err,
                        output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = out_data;
    err = out_err;
    if (!out_valid) check("result_timeout", 64'd0, 64'd1);
  endtask

  task automatic directed(input string tag, input logic [30:0] d, input logic [30:0] exp_d,
                          input logic exp_e);
    logic [30:0] r;
    logic        e;
    int          lat;
    run_op(d, r, e, lat);
    check({tag, "_data"}, 64'(r), 64'(exp_d));
    check({tag, "_err"}, 64'(e), 64'(exp_e));
    check({tag, "_lat"}, 64'(lat), 64'(exp_latency(d)));
  endtask

  initial begin
    logic [30:0] r, held_d, a;
    logic        e, held_e;
    int          lat, guard, transfers, spurious, sent, got, cyc;
    int          acc_cyc[5];
    logic [30:0] vals[5];
    logic [30:0] results[$];

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);

    // Directed values
    directed("inv2", 31'd2, 31'h40000000, 1'b0);
    directed("inv3", 31'd3, 31'h55555555, 1'b0);
    directed("inv1", 31'd1, 31'd1, 1'b0);
    directed("invm1", 31'h7FFFFFFE, 31'h7FFFFFFE, 1'b0);
    directed("zero", 31'd0, 31'd0, 1'b1);
    directed("zero_nc", 31'h7FFFFFFF, 31'd0, 1'b1);

    // Random nonzero inputs
    for (int n = 0; n < 1000; n++) begin
      a = 31'($urandom_range(32'h7FFFFFFE, 1));
      run_op(a, r, e, lat);
      check("rand_model", 64'(r), mpow(64'(a), 64'(EXP)));
      check("rand_product", (64'(a) * 64'(r)) % PM, 64'd1);
      if (n < 8) begin
        check("rand_err", 64'(e), 64'd0);
        check("rand_lat", 64'(lat), 64'(exp_latency(a)));
      end
    end

    // Backpressure
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 31'd5;
    @(negedge clk);
    in_data = 31'd7;  // second offer, held through the busy period
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("bp_seen_valid", 64'(out_valid), 64'd1);
    held_d = out_data;
    held_e = out_err;
    check("bp_data", 64'(held_d), mpow(64'd5, 64'(EXP)));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_data_hold", 64'(out_data), 64'(held_d));
      check("bp_err_hold", 64'(out_err), 64'(held_e));
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    transfers = 0;
    @(posedge clk);
    if (out_valid && out_ready) transfers++;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_after_valid", 64'(out_valid), 64'd0);
    check("bp_after_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid) transfers++;
      check("bp_no_accept", 64'(in_ready), 64'd1);
    end
    check("bp_transfers", 64'(transfers), 64'd1);

    // Reset abort at step 20
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 31'd2;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
    check("abort_out_err", 64'(out_err), 64'd0);
    spurious = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check("abort_spurious", 64'(spurious), 64'd0);
    directed("post_abort", 31'd2, 31'h40000000, 1'b0);

    // Back-to-back streaming
    for (int k = 0; k < 5; k++) vals[k] = 31'($urandom_range(32'h7FFFFFFE, 1));
    sent = 0;
    got  = 0;
    cyc  = 0;
    out_ready = 1'b1;
    while (got < 5 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        results.push_back(out_data);
        got++;
      end
      if (in_ready) begin
        if (sent < 5) begin
          in_valid     = 1'b1;
          in_data      = vals[sent];
          acc_cyc[sent] = cyc;
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    check("stream_count", 64'(results.size()), 64'd5);
    for (int k = 1; k < 5; k++)
      check("stream_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(steps_n() + 2));
    for (int k = 0; k < 5; k++) begin
      if (k < results.size())
        check("stream_order", 64'(results[k]), mpow(64'(vals[k]), 64'(EXP)));
      else
        check("stream_missing", 64'd0, 64'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/m31_inverter.md
# m31_inverter

Sequential multiplicative inverter over the Mersenne-31 field (p = 2^31 − 1). It computes a^(p−2) by left-to-right square-and-multiply around one single-cycle M31 modular multiply-and-reduce datapath. It sits beside the M31 multiplier as the division side of the field arithmetic, and is used wherever a field element must be divided out (normalisation, batch-inverse tails). Both ends use a valid/ready handshake, so the block can be placed between pipelined arithmetic stages.

## Interface
- EXPONENT, 31'h7FFFFFFD (p−2): exponent applied to the input. Non-default values are for verification only and must be nonzero.
- DATA_WIDTH, 31: field element width. Fixed at 31; any other value is a elaboration error.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  input element offered.
- in_ready  out  1  block can accept; equals (state == IDLE).
- in_data  in  31  input element; 0x7FFFFFFF is accepted as the non-canonical zero.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  31  canonical result in [0, p−1].
- out_err  out  1  input was zero (no inverse exists); qualified by out_valid.

## Operation
- States: IDLE, SQUARE, MULT, DONE.
- Reset (reset = 0 at an edge) forces IDLE from any state. Outputs after that edge: in_ready = 1, out_valid = 0, out_data = 0, out_err = 0. The accumulator, base and bit index clear to 0.
- IDLE: on in_valid && in_ready the block:
  - captures base = in_data, mapping 0x7FFFFFFF to 0;
  - sets acc = base;
  - sets bit index i = t−1, where t is the position of the EXPONENT MSB;
  - sets zero_flag = (base == 0);
  - moves to SQUARE.
- If t = 0 (EXPONENT = 1), the block goes directly to DONE.
- SQUARE: acc ← acc·acc mod p. Then:
  - if EXPONENT[i] = 1, go to MULT;
  - else if i == 0, go to DONE;
  - else decrement i and stay in SQUARE.
- MULT: acc ← acc·base mod p. Then go to DONE if i == 0; otherwise decrement i and return to SQUARE.
- DONE:
  - out_valid = 1, out_data = acc, out_err = zero_flag;
  - out_data and out_err stay stable while out_ready = 0;
  - on out_valid && out_ready the block returns to IDLE, and out_valid drops on the next cycle.
- Multiply/reduce:
  - full 62-bit product, folded as lo31 + hi31, with one conditional subtract of p;
  - the result is always canonical;
  - 0·x = 0.
- in_ready stays 0 through SQUARE, MULT and DONE. A new input cannot be accepted in the same cycle the result is taken; there is at least one IDLE cycle between operations.

## Timing
- Compute steps N = t + (popcount(EXPONENT) − 1). With the default exponent, t = 30 and popcount = 30, so N = 59.
- Acceptance at edge k puts the block in SQUARE for the cycle after edge k. The step edges are k+1 … k+N.
- out_valid is first high in the cycle after edge k+N. Default: acceptance to out_valid is 60 cycles.
- Minimum accept-to-accept interval with out_ready held high is N+2 cycles (61 for the default).
- reset low on any edge mid-computation aborts the operation. No out_valid is produced for the aborted input.
- in_valid while in_ready = 0 is ignored. The source must hold its data until the handshake.

## Configuration
- M31_INV_ZERO_BYPASS_EN defined:
  - a zero input (0 or 0x7FFFFFFF) goes from IDLE directly to DONE with acc = 0 and out_err = 1;
  - out_valid appears in the cycle after the acceptance edge;
  - nonzero inputs are unaffected.
- Not defined:
  - zero inputs run the full N steps;
  - out_data = 0 and out_err = 1 at the normal 60-cycle latency.

## Test plan
- in_data = 2 → out_data = 0x40000000, out_err = 0, out_valid in the 60th cycle after acceptance. in_data = 3 → out_data = 0x55555555.
- in_data = 1 → out_data = 1. in_data = 0x7FFFFFFE → out_data = 0x7FFFFFFE. 1000 random nonzero values: (in · out) mod p == 1.
- in_data = 0 and in_data = 0x7FFFFFFF → out_data = 0, out_err = 1. Latency is 1 cycle with M31_INV_ZERO_BYPASS_EN defined and 60 cycles without.
- Backpressure: out_ready = 0 for 10 cycles after out_valid rises. out_data and out_err stay stable, in_ready = 0, and a second in_valid is not accepted. Raising out_ready gives exactly one transfer, then in_ready = 1 on the next cycle.
- Drive reset low for one edge at step 20 of a computation. Afterwards: in_ready = 1, out_valid = 0, out_data = 0, out_err = 0, with no spurious result. A following input of 2 yields 0x40000000.
- Back-to-back: with in_valid and out_ready held high, the bench streams 5 inputs. Acceptances are exactly 61 cycles apart and results appear in order.
